// File: rtl/adder_tree_accum.sv
// adder_tree_accum: pipelined signed/unsigned adder tree that accumulates ACC_PASSES partial sums and saturates the result
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          0 flushes all state synchronously
//   sign_mode       1 = signed lanes, 0 = unsigned lanes (sampled with in_valid)
//   in_valid        in_data holds a valid pass
//   in_data         NUM_IN packed lanes of IN_W bits
//   out_valid       one-cycle pulse with out_data/out_sat
//   out_data        saturated accumulated sum
//   out_sat         result was clamped
//   pass_cnt        passes accumulated in the current group
module adder_tree_accum #(
  parameter int NUM_IN = 8,
  parameter int IN_W = 7,
  parameter int ACC_PASSES = 4,
  parameter int OUT_W = 10,
  localparam int LVL = $clog2(NUM_IN),
  localparam int TREE_W = IN_W + LVL,
  localparam int CNT_W = $clog2(ACC_PASSES) + 1,
  localparam int ACC_W = TREE_W + $clog2(ACC_PASSES) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sign_mode,
  input  logic                    in_valid,
  input  logic [NUM_IN*IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        pass_cnt
);
  localparam logic signed [ACC_W:0] S_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] S_MIN = (ACC_W+1)'(-(1 << (OUT_W-1)));
  localparam logic signed [ACC_W:0] U_MAX = (ACC_W+1)'((1 << OUT_W) - 1);
  // inputs are registered before the tree so the output lands LVL+1 edges after sampling
  logic [NUM_IN*IN_W-1:0] r_in;
  logic r_in_v, r_in_m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_in <= '0;
      r_in_v <= 1'b0;
      r_in_m <= 1'b0;
    end else begin
      r_in <= enable ? in_data : '0;
      r_in_v <= enable & in_valid;
      r_in_m <= enable & sign_mode;
    end
  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int N = NUM_IN >> k;
    localparam int W = IN_W + k;
    logic [2*N*(W-1)-1:0] w_src;
    logic w_src_v, w_src_m;
    logic [N*W-1:0] w_sum, r_sum;
    logic r_v, r_m;
    if (k == 1) begin : g_first
      assign w_src = r_in;
      assign w_src_v = r_in_v;
      assign w_src_m = r_in_m;
    end else begin : g_rest
      assign w_src = g_lvl[k-1].r_sum;
      assign w_src_v = g_lvl[k-1].r_v;
      assign w_src_m = g_lvl[k-1].r_m;
    end
    // each pair grows by one bit, extended by sign or zero per the travelling mode bit
    for (genvar j = 0; j < N; j++) begin : g_add
      logic [W-2:0] w_a, w_b;
      assign w_a = w_src[2*j*(W-1) +: W-1];
      assign w_b = w_src[(2*j+1)*(W-1) +: W-1];
      assign w_sum[j*W +: W] = {w_src_m & w_a[W-2], w_a} + {w_src_m & w_b[W-2], w_b};
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_sum <= '0;
        r_v <= 1'b0;
        r_m <= 1'b0;
      end else begin
        r_sum <= enable ? w_sum : '0;
        r_v <= enable & w_src_v;
        r_m <= enable & w_src_m;
      end
  end
  logic [TREE_W-1:0] w_tree;
  logic w_tree_v, w_tree_m;
  assign w_tree = g_lvl[LVL].r_sum;
  assign w_tree_v = g_lvl[LVL].r_v;
  assign w_tree_m = g_lvl[LVL].r_m;
  logic signed [ACC_W-1:0] r_acc, w_full;
  logic signed [ACC_W:0] w_wide, w_max, w_min;
  logic w_hi, w_lo;
  logic [OUT_W-1:0] w_sat_data;
  assign w_full = r_acc + $signed({{(ACC_W-TREE_W){w_tree_m & w_tree[TREE_W-1]}}, w_tree});
  // one extra bit lets signed and unsigned limits share a single signed compare
  assign w_wide = {w_full[ACC_W-1], w_full};
  assign w_max = w_tree_m ? S_MAX : U_MAX;
  assign w_min = w_tree_m ? S_MIN : '0;
  assign w_hi = w_wide > w_max;
  assign w_lo = w_wide < w_min;
  assign w_sat_data = w_hi ? w_max[OUT_W-1:0] : w_lo ? w_min[OUT_W-1:0] : w_full[OUT_W-1:0];
  logic [CNT_W-1:0] r_cnt;
  logic r_out_v, r_out_s;
  logic [OUT_W-1:0] r_out_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_out_v <= 1'b0;
      r_out_d <= '0;
      r_out_s <= 1'b0;
    end else if (!enable) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_out_v <= 1'b0;
      r_out_d <= '0;
      r_out_s <= 1'b0;
    end else begin
      r_out_v <= 1'b0;
      if (w_tree_v) begin
        if (r_cnt == CNT_W'(ACC_PASSES-1)) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_out_v <= 1'b1;
          r_out_d <= w_sat_data;
          r_out_s <= w_hi | w_lo;
        end else begin
          r_acc <= w_full;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  assign out_valid = r_out_v;
  assign out_data = r_out_d;
  assign out_sat = r_out_s;
  assign pass_cnt = r_cnt;
endmodule

// File: tb/tb_adder_tree_accum.sv
module tb_adder_tree_accum;
  localparam int NUM_IN = 8, IN_W = 7, ACC_PASSES = 4, OUT_W = 10;
  localparam int LAT = 4, DW = NUM_IN*IN_W, CW = $clog2(ACC_PASSES) + 1;
  logic clk = 0, rst_n = 0, enable = 0, sign_mode = 0, in_valid = 0;
  logic [DW-1:0] in_data = '0;
  logic out_valid, out_sat;
  logic [OUT_W-1:0] out_data;
  logic [CW-1:0] pass_cnt;
  adder_tree_accum #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_PASSES(ACC_PASSES), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sign_mode(sign_mode), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .pass_cnt(pass_cnt));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int data; int sat; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int m_acc = 0, m_cnt = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic logic [DW-1:0] fill(int v);
    logic [DW-1:0] r;
    for (int i = 0; i < NUM_IN; i++) r[i*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction
  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    q.delete();
  endtask
  // called at a falling edge; the next rising edge samples the inputs
  task automatic drive(bit en, bit v, bit m, logic [DW-1:0] d);
    enable = en;
    in_valid = v;
    sign_mode = m;
    in_data = d;
    if (!en) model_clear();
    else if (v) begin
      int s = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        logic [IN_W-1:0] ln;
        ln = d[i*IN_W +: IN_W];
        s += m ? int'($signed(ln)) : int'(ln);
      end
      m_acc += s;
      m_cnt++;
      if (m_cnt == ACC_PASSES) begin
        int lo, hi, r;
        lo = m ? -(1 << (OUT_W-1)) : 0;
        hi = m ? (1 << (OUT_W-1)) - 1 : (1 << OUT_W) - 1;
        r = m_acc < lo ? lo : m_acc > hi ? hi : m_acc;
        q.push_back('{r & ((1 << OUT_W) - 1), int'(r != m_acc), cyc + 1 + LAT});
        m_acc = 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, '0);
  endtask
  task automatic passes(int n, bit m, int v);
    for (int i = 0; i < n; i++) drive(1, 1, m, fill(v));
  endtask
  task automatic chk_cleared(string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_sat"}, int'(out_sat), 0);
    chk({tag, "_pass_cnt"}, int'(pass_cnt), 0);
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: out_valid=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_sat", int'(out_sat), e.sat);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before the bench finished");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst_n = 1;
    idle(2);
    passes(4, 1, 1);
    for (int i = 1; i <= ACC_PASSES; i++) begin
      idle(1);
      chk("pass_cnt_seq", int'(pass_cnt), i % ACC_PASSES);
    end
    idle(4);
    passes(4, 1, -64);
    idle(6);
    passes(4, 0, 127);
    idle(6);
    for (int k = 0; k < 8; k++) drive(1, 1, 1, fill(k));
    idle(6);
    passes(2, 1, 3);
    idle(3);
    passes(2, 1, 3);
    idle(6);
    passes(2, 1, 3);
    idle(4);
    chk("pass_cnt_before_flush", int'(pass_cnt), 2);
    drive(0, 1, 1, fill(3));
    chk("flush_pass_cnt", int'(pass_cnt), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    passes(4, 1, 1);
    idle(6);
    passes(4, 0, 127);
    idle(6);
    passes(2, 0, 5);
    idle(4);
    chk("pass_cnt_before_reset", int'(pass_cnt), 2);
    #2;
    rst_n = 0;
    model_clear();
    #1;
    chk_cleared("async_reset");
    #1;
    rst_n = 1;
    @(negedge clk);
    passes(4, 0, 2);
    idle(6);
    begin
      bit m = 0;
      for (int i = 0; i < 300; i++) begin
        bit en, v;
        en = $urandom_range(0, 19) != 0;
        v = $urandom_range(0, 3) != 0;
        if (m_cnt == 0) m = 1'($urandom_range(0, 1));
        drive(en, v, m, DW'({$urandom(), $urandom()}));
      end
    end
    idle(8);
    chk("pending_at_end", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
